mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/multu_core.sv | 11 +
 rtl/mdu_ctrl.sv | 108 ++++++++++
 tb/tb_mdu_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide-unit controller: op codes, FSM states,
// default pipeline depth and 64-bit sign helpers. Signed support is gated by MDU_SIGNED_EN.
package mdu_pkg;

    localparam int LATENCY_DEF = 4;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which is
    // still the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        mag32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        neg64 = ~v + 64'd1;
    endfunction

endpackage

// File: rtl/multu_core.sv
// Unsigned 32x32 -> 64 multiplier. Operands are held stable by the controller for
// the whole RUN phase, so the product only has to settle before the WRITE edge.
module multu_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    assign p = 64'(a) * 64'(b);

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply controller: IDLE -> RUN (LATENCY cycles) -> WRITE, plus MTHI/MTLO.
// Define MDU_SIGNED_EN to make MULT a signed multiply; otherwise MULT equals MULTU.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        req_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [63:0] prod;
    logic [63:0] result;

    // Valid/ready: a request transfers on a rising edge where req_valid && req_ready;
    // the requester holds req_valid and operands stable until then.
    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    multu_core u_core (
        .a (op_a),
        .b (op_b),
        .p (prod)
    );

`ifdef MDU_SIGNED_EN
    logic sign_q;
    assign result = sign_q ? neg64(prod) : prod;
`else
    assign result = prod;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
`ifdef MDU_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        case (req_op)
                            OP_MULTU, OP_MULT: begin
`ifdef MDU_SIGNED_EN
                                if (req_op == OP_MULT) begin
                                    op_a   <= mag32(rs_val);
                                    op_b   <= mag32(rt_val);
                                    sign_q <= rs_val[31] ^ rt_val[31];
                                end else begin
                                    op_a   <= rs_val;
                                    op_b   <= rt_val;
                                    sign_q <= 1'b0;
                                end
`else
                                op_a <= rs_val;
                                op_b <= rt_val;
`endif
                                cnt   <= CNT_INIT;
                                state <= ST_RUN;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt == 4'd0) begin
                        state <= ST_WRITE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WRITE: begin
                    hi    <= result[63:32];
                    lo    <= result[31:0];
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: timer-based reference model compared every cycle,
// directed literal cases, then randomized traffic with occasional resets.
module tb_mdu_ctrl;

    localparam int LAT = 4;
    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_MULT  = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        req_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    mdu_ctrl #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .req_ready (req_ready),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Reference model: a pending product plus a count of edges left until it lands.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_prod = 64'd0;
    int          m_left = 0;
    logic        m_done = 1'b0;

    function automatic logic [63:0] ref_product(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] r;
        r = {32'd0, a} * {32'd0, b};
`ifdef MDU_SIGNED_EN
        if (op == OP_MULT) r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hi   = m_prod[63:32];
                m_lo   = m_prod[31:0];
                m_done = 1'b1;
            end
        end else if (req_valid) begin
            if (req_op == OP_MULTU || req_op == OP_MULT) begin
                m_prod = ref_product(req_op, rs_val, rt_val);
                m_left = LAT + 1;
            end else if (req_op == OP_MTHI) begin
                m_hi = rs_val;
            end else begin
                m_lo = rs_val;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_ready", 64'(req_ready), 64'(m_left == 0));
            check("cmp_busy",  64'(busy),      64'(m_left != 0));
            check("cmp_done",  64'(done),      64'(m_done));
            check("cmp_hi",    64'(hi),        64'(m_hi));
            check("cmp_lo",    64'(lo),        64'(m_lo));
        end
    end

    // Present a request and hold it until it transfers; reports done/lo seen in the
    // cycle the transfer was granted.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic saw_done, output logic [31:0] saw_lo);
        bit got;
        got = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        rs_val    = a;
        rt_val    = b;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        saw_done = done;
        saw_lo   = lo;
        if (!got) check("issue_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rs_val    = $urandom;
        rt_val    = $urandom;
        req_op    = 2'($urandom_range(0, 3));
    endtask

    // Counts negedges (and busy cycles among them) from acceptance up to the done pulse.
    task automatic wait_done(output int edges, output int busy_n);
        edges  = -1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) check("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        sd;
        logic [31:0] sl;
        int          edges;
        int          bn;
        int          done_cnt;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_hilo",  {hi, lo}, 64'd0);
        check("rst_done",  64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Largest unsigned product; done and busy timing pinned to LATENCY=4.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sd, sl);
        wait_done(edges, bn);
        check("max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("max_lo", 64'(lo), 64'h0000_0001);
        check("max_done_edge", 64'(edges), 64'd5);
        check("max_busy_cycles", 64'(bn), 64'd5);

        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, sd, sl);
        wait_done(edges, bn);
        check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
`ifdef MDU_SIGNED_EN
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
`else
        check("mult_hi", 64'(hi), 64'h0000_0004);
`endif

        issue(OP_MTHI, 32'h1234_5678, 32'd0, sd, sl);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, sd, sl);
        @(negedge clk);
        check("mt_hi", 64'(hi), 64'h1234_5678);
        check("mt_lo", 64'(lo), 64'h9ABC_DEF0);
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_done", 64'(done), 64'd0);

        // Second request held through busy transfers in the done cycle.
        issue(OP_MULTU, 32'd7, 32'd6, sd, sl);
        issue(OP_MULTU, 32'd2, 32'd3, sd, sl);
        check("b2b_done_cycle", 64'(sd), 64'd1);
        check("b2b_first_lo", 64'(sl), 64'h2A);
        wait_done(edges, bn);
        check("b2b_second_lo", 64'(lo), 64'h6);
        check("b2b_second_hi", 64'(hi), 64'h0);

        // Reset in the middle of a multiply discards it.
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, sd, sl);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_mid_no_done", 64'(done_cnt), 64'd0);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), sd, sl);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        repeat (LAT + 4) @(posedge clk);
        @(negedge clk);
        check("end_idle", 64'(busy), 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
